// File: rtl/gbsha_fir_pkg.sv
// Shared types and helpers for the time-multiplexed FIR sequencer.
package gbsha_fir_pkg;

   typedef enum logic [1:0] {
      LOAD = 2'd0,
      IDLE = 2'd1,
      MAC  = 2'd2,
      DONE = 2'd3
   } fir_state_e;

   function automatic int tap_idx_w(input int n_taps);
      return (n_taps > 1) ? $clog2(n_taps) : 1;
   endfunction

   // One guard bit above the worst-case sum so the accumulator never wraps.
   function automatic int acc_w(input int n_taps, input int bw_in);
      return 2 * bw_in + $clog2(n_taps) + 1;
   endfunction

   function automatic logic signed [31:0] saturate(input logic signed [63:0] v,
                                                   input int bw_out);
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      hi = (64'sd1 <<< (bw_out - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (bw_out - 1));
      if (v > hi) return hi[31:0];
      if (v < lo) return lo[31:0];
      return v[31:0];
   endfunction

endpackage

// File: rtl/gbsha_sm_mult.sv
// Combinational sign-magnitude multiplier; magnitudes are unsigned so -2^(BW_in-1) fits.
module gbsha_sm_mult #(
   parameter int BW_in = 6
) (
   input  logic [BW_in-1:0]        mag_a,
   input  logic                    sign_a,
   input  logic [BW_in-1:0]        mag_b,
   input  logic                    sign_b,
   output logic signed [2*BW_in:0] prod
);

   logic [2*BW_in-1:0]      prod_mag;
   logic signed [2*BW_in:0] prod_pos;

   assign prod_mag = (2*BW_in)'(mag_a) * (2*BW_in)'(mag_b);
   assign prod_pos = signed'({1'b0, prod_mag});
   assign prod     = (sign_a ^ sign_b) ? -prod_pos : prod_pos;

endmodule

// File: rtl/gbsha_fir_sequencer.sv
// FIR controller: coefficient load, then one shared multiplier stepped over all taps per sample.
//
// state | meaning
// LOAD  | accepting coefficients 0..N_TAPS-1, coeff_ready high
// IDLE  | waiting for a sample, sample_ready high
// MAC   | one tap per cycle into the accumulator
// DONE  | saturate accumulator into y_out, pulse y_valid
module gbsha_fir_sequencer
   import gbsha_fir_pkg::*;
#(
   parameter int N_TAPS    = 5,
   parameter int BW_in     = 6,
   parameter int BW_out    = 8,
   parameter int OUT_SHIFT = 0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              coeff_valid,
   output logic              coeff_ready,
   input  logic [BW_in-1:0]  coeff_in,
   input  logic              sample_valid,
   output logic              sample_ready,
   input  logic [BW_in-1:0]  sample_in,
   output logic              y_valid,
   output logic [BW_out-1:0] y_out,
   output logic              busy
);

   localparam int ACC_W  = acc_w(N_TAPS, BW_in);
   localparam int TAP_W  = tap_idx_w(N_TAPS);
   localparam int PROD_W = 2 * BW_in + 1;
   localparam logic [TAP_W-1:0] LAST_TAP = TAP_W'(N_TAPS - 1);

   fir_state_e              state_q, state_d;
   logic [TAP_W-1:0]        load_idx_q, load_idx_d;
   logic [TAP_W-1:0]        tap_q, tap_d;
   logic [BW_in-1:0]        x_mag_q [N_TAPS];
   logic [BW_in-1:0]        x_mag_d [N_TAPS];
   logic [N_TAPS-1:0]       x_sgn_q, x_sgn_d;
   logic [BW_in-1:0]        c_mag_q [N_TAPS];
   logic [BW_in-1:0]        c_mag_d [N_TAPS];
   logic [N_TAPS-1:0]       c_sgn_q, c_sgn_d;
   logic signed [ACC_W-1:0] acc_q, acc_d;
   logic [BW_out-1:0]       y_out_q, y_out_d;
   logic                    y_valid_q, y_valid_d;
   logic signed [PROD_W-1:0] prod;

   function automatic logic [BW_in-1:0] mag_of(input logic [BW_in-1:0] v);
      return v[BW_in-1] ? (~v + BW_in'(1)) : v;
   endfunction

   gbsha_sm_mult #(.BW_in(BW_in)) u_mult (
      .mag_a  (x_mag_q[tap_q]),
      .sign_a (x_sgn_q[tap_q]),
      .mag_b  (c_mag_q[tap_q]),
      .sign_b (c_sgn_q[tap_q]),
      .prod   (prod)
   );

   assign coeff_ready  = (state_q == LOAD);
   assign sample_ready = (state_q == IDLE);
   assign busy         = (state_q == MAC) || (state_q == DONE);
   assign y_valid      = y_valid_q;
   assign y_out        = y_out_q;

   always_comb begin
      state_d    = state_q;
      load_idx_d = load_idx_q;
      tap_d      = tap_q;
      x_mag_d    = x_mag_q;
      x_sgn_d    = x_sgn_q;
      c_mag_d    = c_mag_q;
      c_sgn_d    = c_sgn_q;
      acc_d      = acc_q;
      y_out_d    = y_out_q;
      y_valid_d  = 1'b0;
      unique case (state_q)
         LOAD: begin
            if (coeff_valid && coeff_ready) begin
               c_mag_d[load_idx_q] = mag_of(coeff_in);
               c_sgn_d[load_idx_q] = coeff_in[BW_in-1];
               load_idx_d          = load_idx_q + TAP_W'(1);
               if (load_idx_q == LAST_TAP) state_d = IDLE;
            end
         end
         IDLE: begin
            if (sample_valid && sample_ready) begin
               for (int i = N_TAPS - 1; i > 0; i--) begin
                  x_mag_d[i] = x_mag_q[i-1];
                  x_sgn_d[i] = x_sgn_q[i-1];
               end
               x_mag_d[0] = mag_of(sample_in);
               x_sgn_d[0] = sample_in[BW_in-1];
               acc_d      = '0;
               tap_d      = '0;
               state_d    = MAC;
            end
         end
         MAC: begin
            acc_d = acc_q + ACC_W'(prod);
            tap_d = tap_q + TAP_W'(1);
            if (tap_q == LAST_TAP) state_d = DONE;
         end
         DONE: begin
            y_out_d   = BW_out'(saturate(64'(acc_q >>> OUT_SHIFT), BW_out));
            y_valid_d = 1'b1;
            state_d   = IDLE;
         end
         default: state_d = LOAD;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= LOAD;
         load_idx_q <= '0;
         tap_q      <= '0;
         x_sgn_q    <= '0;
         c_sgn_q    <= '0;
         acc_q      <= '0;
         y_out_q    <= '0;
         y_valid_q  <= 1'b0;
         for (int i = 0; i < N_TAPS; i++) begin
            x_mag_q[i] <= '0;
            c_mag_q[i] <= '0;
         end
      end else begin
         state_q    <= state_d;
         load_idx_q <= load_idx_d;
         tap_q      <= tap_d;
         x_mag_q    <= x_mag_d;
         x_sgn_q    <= x_sgn_d;
         c_mag_q    <= c_mag_d;
         c_sgn_q    <= c_sgn_d;
         acc_q      <= acc_d;
         y_out_q    <= y_out_d;
         y_valid_q  <= y_valid_d;
      end
   end

endmodule
